// File: rtl/map_mem_arbiter.sv
// Round-robin arbiter sharing the single-port tile-map RAM between requesters.
// Reads return a one-hot rvalid tag RD_LATENCY cycles after the grant; writes return nothing.
module map_mem_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_we,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW:0] NREQ = (IW+1)'(NUM_REQ);

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_v;
  assign addr_v  = addr;
  assign wdata_v = wdata;

  logic [IW-1:0]   ptr, gidx, ptr_nxt;
  logic [IW:0]     scan;
  logic            hit;
  logic [NUM_REQ-1:0] rd_tag;
  logic [RD_LATENCY:1][NUM_REQ-1:0] vld_pipe;

  // Scan ptr, ptr+1, ... with an explicit modulo so non-power-of-2 counts wrap correctly.
  always_comb begin
    hit  = 1'b0;
    gidx = '0;
    scan = '0;
    for (int o = 0; o < NUM_REQ; o++) begin
      scan = {1'b0, ptr} + (IW+1)'(o);
      if (scan >= NREQ) scan = scan - NREQ;
      if (!hit && req[scan[IW-1:0]]) begin
        hit  = 1'b1;
        gidx = scan[IW-1:0];
      end
    end
    if (rst) hit = 1'b0;
  end

  always_comb begin
    gnt       = '0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (hit) begin
      gnt[gidx] = 1'b1;
      mem_addr  = addr_v[gidx];
      mem_we    = we[gidx];
      mem_wdata = wdata_v[gidx];
    end
    ptr_nxt = ({1'b0, gidx} == NREQ - 1'b1) ? '0 : gidx + 1'b1;
    rd_tag  = gnt & ~we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      vld_pipe <= '0;
    end else begin
      if (hit) ptr <= ptr_nxt;
      vld_pipe[1] <= rd_tag;
      for (int i = 2; i <= RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Masked during reset so a read in flight when reset hits never surfaces.
  assign rvalid = rst ? '0 : vld_pipe[RD_LATENCY];
  assign rdata  = mem_rdata;
endmodule
